// File: rtl/branch_resolve_bht.sv
// Branch target buffer with 2-bit saturating history, plus EX-stage control-flow
// resolution: mispredict and redirect generation, table update and statistics.
module branch_resolve_bht #(
  parameter int ADDR_BIT = 10,
  parameter int IDX_BIT  = 5,
  parameter int CNT_BIT  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_BIT-1:0] if_pc,
  output logic [ADDR_BIT-1:0] pred_pc,
  output logic [1:0]          pred_bht_state,
  input  logic                ex_fire,
  input  logic [ADDR_BIT-1:0] ex_pc_4,
  input  logic [ADDR_BIT-1:0] ex_pc_guessed,
  input  logic [1:0]          ex_bht_state,
  input  logic                ex_is_branch,
  input  logic                ex_is_jump,
  input  logic                ex_taken,
  input  logic [ADDR_BIT-1:0] ex_target,
  output logic                mispredict,
  output logic [ADDR_BIT-1:0] redirect_pc,
  output logic [CNT_BIT-1:0]  branch_cnt,
  output logic [CNT_BIT-1:0]  miss_cnt
);
  localparam int ENTRIES = 1 << IDX_BIT;
  localparam int TAG_BIT = ADDR_BIT - IDX_BIT;
  localparam logic [ADDR_BIT-1:0] ADDR_ONE = 1;
  localparam logic [CNT_BIT-1:0]  CNT_ONE  = 1;

  logic                valid_q [ENTRIES];
  logic [TAG_BIT-1:0]  tag_q   [ENTRIES];
  logic [ADDR_BIT-1:0] tgt_q   [ENTRIES];
  logic [1:0]          state_q [ENTRIES];
  logic [CNT_BIT-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_BIT-1:0]  miss_cnt_q, miss_cnt_d;

  function automatic logic [1:0] sat_step(input logic [1:0] s, input logic up);
    if (up) return (s == 2'b11) ? s : s + 2'b01;
    return (s == 2'b00) ? s : s - 2'b01;
  endfunction

  function automatic logic [CNT_BIT-1:0] sat_inc(input logic [CNT_BIT-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_ONE : c;
  endfunction

  // IF lookup: reads the table as it stands before this cycle's update.
  logic [IDX_BIT-1:0] lk_idx;
  logic [TAG_BIT-1:0] lk_tag;
  logic               lk_hit;

  assign lk_idx         = if_pc[IDX_BIT-1:0];
  assign lk_tag         = if_pc[ADDR_BIT-1:IDX_BIT];
  assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_bht_state = lk_hit ? state_q[lk_idx] : 2'b01;
  assign pred_pc        = (lk_hit && state_q[lk_idx][1]) ? tgt_q[lk_idx] : if_pc + ADDR_ONE;

  // EX resolution
  logic [ADDR_BIT-1:0] ex_pc;
  logic [IDX_BIT-1:0]  ex_idx;
  logic [TAG_BIT-1:0]  ex_tag;
  logic                ex_hit;
  logic                ex_ctl;
  logic [ADDR_BIT-1:0] actual_pc;

  assign ex_pc       = ex_pc_4 - ADDR_ONE;
  assign ex_idx      = ex_pc[IDX_BIT-1:0];
  assign ex_tag      = ex_pc[ADDR_BIT-1:IDX_BIT];
  assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_ctl      = ex_is_branch | ex_is_jump;
  assign actual_pc   = (ex_is_jump || (ex_is_branch && ex_taken)) ? ex_target : ex_pc_4;
  assign mispredict  = ex_fire && (actual_pc != ex_pc_guessed);
  assign redirect_pc = ex_fire ? actual_pc : '0;

  logic                entry_we;
  logic                entry_valid_d;
  logic [ADDR_BIT-1:0] entry_tgt_d;
  logic [1:0]          entry_state_d;

  // Branch hits step from the history carried down the pipe, not the live entry.
  always_comb begin
    entry_we      = 1'b0;
    entry_valid_d = valid_q[ex_idx];
    entry_tgt_d   = tgt_q[ex_idx];
    entry_state_d = state_q[ex_idx];
    if (ex_fire) begin
      if (ex_is_jump) begin
        entry_we      = 1'b1;
        entry_valid_d = 1'b1;
        entry_tgt_d   = ex_target;
        entry_state_d = 2'b11;
      end else if (ex_is_branch) begin
        entry_we      = 1'b1;
        entry_valid_d = 1'b1;
        if (ex_hit) begin
          entry_state_d = sat_step(ex_bht_state, ex_taken);
          if (ex_taken) entry_tgt_d = ex_target;
        end else begin
          entry_tgt_d   = ex_target;
          entry_state_d = ex_taken ? 2'b10 : 2'b01;
        end
      end else if (ex_hit) begin
        entry_we      = 1'b1;
        entry_valid_d = 1'b0;
      end
    end
  end

  assign branch_cnt_d = sat_inc(branch_cnt_q, ex_fire && ex_ctl);
  assign miss_cnt_d   = sat_inc(miss_cnt_q, mispredict);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        state_q[i] <= 2'b01;
      end
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (entry_we) begin
        valid_q[ex_idx] <= entry_valid_d;
        tag_q[ex_idx]   <= ex_tag;
        tgt_q[ex_idx]   <= entry_tgt_d;
        state_q[ex_idx] <= entry_state_d;
      end
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench for branch_resolve_bht: directed scenarios plus random traffic
// checked against an array-based behavioural model of the predictor.
module tb_branch_resolve_bht;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] if_pc = '0;
  logic [9:0] pred_pc;
  logic [1:0] pred_bht_state;
  logic       ex_fire = 1'b0;
  logic [9:0] ex_pc_4 = '0;
  logic [9:0] ex_pc_guessed = '0;
  logic [1:0] ex_bht_state = '0;
  logic       ex_is_branch = 1'b0;
  logic       ex_is_jump = 1'b0;
  logic       ex_taken = 1'b0;
  logic [9:0] ex_target = '0;
  logic       mispredict;
  logic [9:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  branch_resolve_bht #(.ADDR_BIT(10), .IDX_BIT(5), .CNT_BIT(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_pc(pred_pc),
    .pred_bht_state(pred_bht_state), .ex_fire(ex_fire), .ex_pc_4(ex_pc_4),
    .ex_pc_guessed(ex_pc_guessed), .ex_bht_state(ex_bht_state),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken),
    .ex_target(ex_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ppc;
    int pst;
    int mis;
    int redir;
    int bc;
    int mc;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference predictor: one record per table slot, plain integers.
  bit m_v[32];
  int m_tag[32];
  int m_tgt[32];
  int m_st[32];
  int m_bc;
  int m_mc;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_st[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic model_lookup(input int pc, output int ppc, output int pst);
    int i;
    bit hit;
    i = pc % 32;
    hit = m_v[i] && (m_tag[i] == pc / 32);
    pst = hit ? m_st[i] : 1;
    ppc = (hit && pst >= 2) ? m_tgt[i] : (pc + 1) % 1024;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pred_pc", int'(pred_pc), e.ppc);
      chk("pred_bht_state", int'(pred_bht_state), e.pst);
      chk("mispredict", int'(mispredict), e.mis);
      chk("redirect_pc", int'(redirect_pc), e.redir);
      chk("branch_cnt", int'(branch_cnt), e.bc);
      chk("miss_cnt", int'(miss_cnt), e.mc);
    end
  end

  task automatic issue(input int ipc, input bit fire, input int pc4, input int guessed,
                       input int bst, input bit br, input bit jmp, input bit tk, input int tgt);
    exp_t e;
    int actual, epc, i;
    bit hit;
    @(posedge clk);
    #1;
    if_pc = ipc[9:0]; ex_fire = fire; ex_pc_4 = pc4[9:0]; ex_pc_guessed = guessed[9:0];
    ex_bht_state = bst[1:0]; ex_is_branch = br; ex_is_jump = jmp; ex_taken = tk;
    ex_target = tgt[9:0];
    model_lookup(ipc, e.ppc, e.pst);
    actual = (jmp || (br && tk)) ? tgt : pc4;
    e.mis = (fire && actual != guessed) ? 1 : 0;
    e.redir = fire ? actual : 0;
    e.bc = m_bc; e.mc = m_mc;
    exp_q.push_back(e);
    if (fire) begin
      epc = (pc4 + 1023) % 1024;
      i = epc % 32;
      hit = m_v[i] && (m_tag[i] == epc / 32);
      if (jmp) begin
        m_v[i] = 1; m_tag[i] = epc / 32; m_tgt[i] = tgt; m_st[i] = 3;
      end else if (br) begin
        if (hit) begin
          m_st[i] = tk ? ((bst == 3) ? 3 : bst + 1) : ((bst == 0) ? 0 : bst - 1);
          if (tk) m_tgt[i] = tgt;
        end else begin
          m_v[i] = 1; m_tag[i] = epc / 32; m_tgt[i] = tgt; m_st[i] = tk ? 2 : 1;
        end
      end else if (hit) begin
        m_v[i] = 0;
      end
      if (br || jmp) m_bc++;
      if (e.mis != 0) m_mc++;
    end
  endtask

  // Reset is raised and released between clock edges so its effect is asynchronous.
  task automatic do_reset(input int ipc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    if_pc = ipc[9:0]; ex_fire = 1'b0;
    model_reset();
    e.ppc = (ipc + 1) % 1024; e.pst = 1; e.mis = 0; e.redir = 0; e.bc = 0; e.mc = 0;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic random_ops(input int n);
    int ipc, epc, pc4, g, s, guessed, bst, typ, sel;
    for (int k = 0; k < n; k++) begin
      ipc = ($urandom % 8 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 127));
      epc = ($urandom % 16 == 0) ? 1023 : int'($urandom_range(0, 127));
      pc4 = (epc + 1) % 1024;
      model_lookup(epc, g, s);
      sel = $urandom % 4;
      guessed = (sel < 2) ? g : (sel == 2) ? pc4 : int'($urandom_range(0, 1023));
      bst = ($urandom % 8 == 0) ? int'($urandom_range(0, 3)) : s;
      typ = $urandom % 4;
      issue(ipc, ($urandom % 5) != 0, pc4, guessed, bst, typ == 1 || typ == 3, typ >= 2,
            $urandom % 2 == 1, int'($urandom_range(0, 1023)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int g, s;
    model_reset();
    do_reset(32'h010);
    issue(32'h010, 1, 32'h011, 32'h011, 1, 1, 0, 1, 32'h040);
    issue(32'h010, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      model_lookup(32'h010, g, s);
      issue(32'h010, 1, 32'h011, g, s, 1, 0, 0, 32'h040);
    end
    issue(32'h010, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(32'h020, 1, 32'h021, 32'h021, 1, 0, 1, 0, 32'h100);
    model_lookup(32'h020, g, s);
    issue(32'h020, 1, 32'h021, g, s, 0, 1, 0, 32'h100);
    issue(32'h030, 1, 32'h031, 32'h031, 1, 0, 0, 0, 0);
    issue(32'h010, 1, 32'h011, 32'h040, 1, 0, 0, 0, 0);
    issue(32'h010, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(32'h005, 1, 32'h006, 32'h006, 1, 0, 1, 0, 32'h100);
    issue(32'h005, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(32'h3FF, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(32'h3FF, 1, 32'h000, 32'h000, 1, 0, 1, 0, 32'h200);
    issue(32'h3FF, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(32'h020, 0, 32'h021, 32'h155, 1, 1, 0, 1, 32'h2AA);
    issue(32'h020, 1, 32'h021, 32'h100, 3, 1, 1, 0, 32'h180);
    random_ops(400);
    do_reset(32'h020);
    issue(32'h020, 0, 0, 0, 0, 0, 0, 0, 0);
    random_ops(100);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Branch target buffer with 2-bit history, plus resolution logic for control flow.
- At IF it produces the guessed next PC and the bht_state that travel down the pipeline.
- At EX it consumes the stage-3 fields (pc_4, pc_guessed, bht_state, is_branch, is_jump) and the resolved outcome. It raises mispredict, which drives the stage-register clears, and supplies the redirect PC.
- It updates the table at the clock edge and keeps branch and miss statistics.

Parameters:
- ADDR_BIT, 10, instruction-memory word-address width; pc_4 = pc + 1.
- IDX_BIT, 5, table index width; the table has 2^IDX_BIT entries.
- CNT_BIT, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  ADDR_BIT  PC currently being fetched
- pred_pc  out  ADDR_BIT  guessed next PC; becomes pc_guessed
- pred_bht_state  out  2  history state at lookup; becomes bht_state
- ex_fire  in  1  stage-3 register holds a valid, non-stalled instruction this cycle
- ex_pc_4  in  ADDR_BIT  pc_4 from stage 3
- ex_pc_guessed  in  ADDR_BIT  pc_guessed from stage 3
- ex_bht_state  in  2  bht_state from stage 3
- ex_is_branch  in  1  conditional branch
- ex_is_jump  in  1  unconditional jump (j/jal/jr)
- ex_taken  in  1  resolved branch condition; ignored for jumps
- ex_target  in  ADDR_BIT  resolved target address
- mispredict  out  1  flush request for the stage registers
- redirect_pc  out  ADDR_BIT  correct next PC; valid while mispredict = 1
- branch_cnt  out  CNT_BIT  resolved control instructions
- miss_cnt  out  CNT_BIT  mispredictions

Behaviour:
- Reset is asynchronous, active-low. It clears every entry to valid=0, tag=0, target=0, state=2'b01. branch_cnt and miss_cnt reset to 0.
- Entry fields: valid, tag = pc[ADDR_BIT-1:IDX_BIT], target, state[1:0]. Index = pc[IDX_BIT-1:0].

Lookup (combinational, zero latency):
- hit = valid && tag matches.
- pred_bht_state = hit ? state : 2'b01.
- pred_pc = (hit && state[1]) ? target : if_pc + 1, computed modulo 2^ADDR_BIT (0x3FF wraps to 0x000).
- When lookup and update hit the same index in the same cycle, lookup returns the pre-update contents. There is no bypass.

Resolution (combinational, only while ex_fire = 1):
- ex_pc = ex_pc_4 - 1, modulo 2^ADDR_BIT.
- ctl = ex_is_branch | ex_is_jump.
- actual = ex_is_jump ? ex_target : (ex_is_branch && ex_taken) ? ex_target : ex_pc_4.
- mispredict = (actual != ex_pc_guessed).
- redirect_pc = actual.
- When ex_fire = 0: mispredict = 0 and redirect_pc = 0.
- A non-control instruction with a wrong guess (a stale or aliased entry) still asserts mispredict, with redirect_pc = ex_pc_4.

Update (posedge clk, only while ex_fire = 1), applied to the entry at index(ex_pc):
- Branch, entry hit: state = saturating step from ex_bht_state, not from the current table state; +1 if taken, -1 if not, clamped to 00..11. If taken, target = ex_target.
- Branch, entry miss: allocate. valid=1, tag set, target = ex_target, state = taken ? 2'b10 : 2'b01.
- Jump (hit or miss): valid=1, tag set, target = ex_target, state = 2'b11.
- Non-control instruction whose tag hits: valid = 0.
- Both ex_is_branch and ex_is_jump set: treat as a jump.

Counters:
- branch_cnt += 1 when ex_fire && ctl.
- miss_cnt += 1 when ex_fire && mispredict.
- Both saturate at all-ones and never wrap.

Reset mid-operation: the table and counters return to their reset values immediately. Outputs then follow the combinational rules above.

Test Plan:
- Cold table, if_pc=0x010 -> pred_pc=0x011, pred_bht_state=01. Then resolve branch: ex_pc_4=0x011, taken, target 0x040, guessed 0x011 -> mispredict=1, redirect_pc=0x040. After the edge, lookup 0x010 gives pred_pc=0x040, state 10, and miss_cnt=1.
- Same branch resolved not-taken 3 times with ex_bht_state fed back -> states 01, 00, 00 (saturated). pred_pc=0x011, and a correct guess gives mispredict=0.
- Jump at pc 0x020 to 0x100 -> entry state 11. Next lookup gives pred_pc=0x100; resolution with guessed 0x100 gives mispredict=0 and branch_cnt increments.
- Alias: the entry for pc 0x010 is valid. A non-control instruction at pc 0x030 (same index, different tag) does not hit, so no invalidation. A non-control instruction at pc 0x010 with ex_pc_guessed=0x040 -> mispredict=1, redirect_pc=0x011, entry invalidated.
- Simultaneous lookup and update on index 5 -> pred_pc reflects old contents that cycle and new contents the next cycle. if_pc=0x3FF with a miss -> pred_pc=0x000.
- ex_fire=0 with a mismatching guess -> mispredict=0, no table or counter change. Assert rst_n low mid-run -> all entries invalid and counters 0 asynchronously.
